uart_command_receiver: RTL and testbench
========================================

UART_COMMAND_RECEIVER -- requirements
Module: uart_command_receiver

Interface
REQ-001 SHALL have parameter TIMEOUT_CYCLES, default 30'd50_000_000, the maximum idle clk cycles allowed between bytes within one frame.
REQ-002 SHALL have port clk  input  1  system clock; all state changes on its rising edge.
REQ-003 SHALL have port reset  input  1  reset; one clock; reset is asynchronous and active-low.
REQ-004 SHALL have port rx_data  input  8  byte from the UART receiver.
REQ-005 SHALL have port rx_valid  input  1  rx_data holds a byte.
REQ-006 SHALL have port rx_ready  output  1  the block can accept a byte; a byte transfers when rx_valid && rx_ready.
REQ-007 SHALL have port cmd_code  output  3  decoded command (cmd_t).
REQ-008 SHALL have port cmd_arg  output  4  decoded argument digit 0-9.
REQ-009 SHALL have port cmd_valid  output  1  cmd_code/cmd_arg are valid.
REQ-010 SHALL have port cmd_ready  input  1  the controller accepts the command; it transfers when cmd_valid && cmd_ready.
REQ-011 SHALL have port err_count  output  8  count of rejected frames, saturating.
REQ-012 SHALL have port tx_data  output  8  acknowledge byte to the UART transmitter.
REQ-013 SHALL have port tx_valid  output  1  tx_data is valid; it transfers when tx_valid && tx_ready.
REQ-014 SHALL have port tx_ready  input  1  the UART transmitter can accept a byte.

Function
REQ-015 SHALL parse each frame as: command letter, then ASCII digit 0x30-0x39, then terminator 0x0A.
REQ-016 SHALL map command letters F=0x46->CMD_FWD, B=0x42->CMD_BACK, L=0x4C->CMD_LEFT, R=0x52->CMD_RIGHT, S=0x53->CMD_STOP; every other letter is invalid.
REQ-017 SHALL implement FSM states IDLE, GET_ARG, GET_TERM, PRESENT, ACK.
REQ-018 SHALL transition IDLE -> GET_ARG on a valid letter and latch the command code; an invalid byte in IDLE SHALL be dropped silently and SHALL NOT count as an error.
REQ-019 SHALL transition GET_ARG -> GET_TERM on a digit and latch cmd_arg = byte - 0x30 (4 bits); a non-digit in GET_ARG SHALL reject the frame.
REQ-020 SHALL transition GET_TERM -> PRESENT on 0x0A; any other byte in GET_TERM SHALL reject the frame.
REQ-021 SHALL assert rx_ready only in IDLE, GET_ARG and GET_TERM.
REQ-022 SHALL assert cmd_valid in PRESENT only, starting the cycle after the terminator is accepted, and hold cmd_code/cmd_arg stable until cmd_ready.
REQ-023 SHALL, on a frame reject, increment err_count saturating at 255 and go to ACK with a NAK result.
REQ-024 SHALL, on a PRESENT handshake, go to ACK with an ACK result.
REQ-025 SHALL run a byte-gap counter that resets on each accepted byte and in IDLE.
REQ-026 SHALL, in GET_ARG or GET_TERM, treat the counter reaching TIMEOUT_CYCLES-1 as a frame reject.
REQ-027 SHALL give an accepted byte priority over a timeout occurring in the same cycle.
REQ-028 SHALL NOT time out in PRESENT; it waits for cmd_ready indefinitely.

Reset
REQ-029 SHALL, with reset low, set state=IDLE, rx_ready=0, cmd_valid=0, cmd_code=CMD_STOP, cmd_arg=0, err_count=0, tx_valid=0, tx_data=0 and gap counter=0, asynchronously.
REQ-030 SHALL discard any partial frame or pending command when reset is asserted mid-operation.
REQ-031 SHALL assert rx_ready in the first cycle after reset is released.

Configuration
REQ-032 SHALL, with CMD_ACK_EN defined, in ACK drive tx_valid=1 with tx_data=0x41 ('A') for an ACK result or 0x4E ('N') for a NAK result, hold until tx_ready, then return to IDLE.
REQ-033 SHALL, with CMD_ACK_EN undefined, pass through ACK in one cycle with tx_valid=0 and tx_data=0; the ports SHALL remain present.

Structure
REQ-034 SHALL place cmd_t (CMD_STOP=0, CMD_FWD, CMD_BACK, CMD_LEFT, CMD_RIGHT), the ASCII constants and the ACK/NAK byte values in shared package robot_cmd_pkg.
REQ-035 SHALL reuse the existing timebase module as the byte-gap counter; no other sub-module is permitted.

Verification
REQ-036 SHALL verify: bytes 0x46,0x33,0x0A with cmd_ready=1 -> cmd_valid for 1 cycle, cmd_code=CMD_FWD, cmd_arg=3; 'A' sent on tx when CMD_ACK_EN is defined.
REQ-037 SHALL verify: 0x53,0x41 -> no cmd_valid, err_count=1, 'N' on tx, next 0x4C,0x39,0x0A -> CMD_LEFT with cmd_arg=9.
REQ-038 SHALL verify: TIMEOUT_CYCLES=100, 0x52 followed by 100 idle cycles -> err_count=1, state IDLE; a byte arriving on cycle 99 is accepted and no error is counted.
REQ-039 SHALL verify: frame completed with cmd_ready=0 for 20 cycles -> cmd_valid and cmd_code/cmd_arg held, rx_ready=0 throughout, a single handshake.
REQ-040 SHALL verify: 256 bad frames -> err_count=255; reset pulsed low mid-frame after 0x42 -> all outputs at reset values, no command emitted.

Source files
------------

// File: rtl/robot_cmd_pkg.sv
// Shared definitions for the robot command path: command codes, receiver FSM
// states, ASCII framing constants, acknowledge byte values and small decode
// helpers used by the UART command receiver.
package robot_cmd_pkg;

  typedef enum logic [2:0] {
    CMD_STOP  = 3'd0,
    CMD_FWD   = 3'd1,
    CMD_BACK  = 3'd2,
    CMD_LEFT  = 3'd3,
    CMD_RIGHT = 3'd4
  } cmd_t;

  typedef enum logic [2:0] {
    IDLE,
    GET_ARG,
    GET_TERM,
    PRESENT,
    ACK
  } state_t;

  localparam logic [7:0] ASCII_F    = 8'h46;
  localparam logic [7:0] ASCII_B    = 8'h42;
  localparam logic [7:0] ASCII_L    = 8'h4C;
  localparam logic [7:0] ASCII_R    = 8'h52;
  localparam logic [7:0] ASCII_S    = 8'h53;
  localparam logic [7:0] ASCII_ZERO = 8'h30;
  localparam logic [7:0] ASCII_NINE = 8'h39;
  localparam logic [7:0] ASCII_LF   = 8'h0A;

  localparam logic [7:0] ACK_BYTE = 8'h41;
  localparam logic [7:0] NAK_BYTE = 8'h4E;

  typedef struct packed {
    logic ok;
    cmd_t code;
  } letter_t;

  function automatic letter_t decode_letter(input logic [7:0] b);
    letter_t r;
    r.ok   = 1'b1;
    r.code = CMD_STOP;
    case (b)
      ASCII_F: r.code = CMD_FWD;
      ASCII_B: r.code = CMD_BACK;
      ASCII_L: r.code = CMD_LEFT;
      ASCII_R: r.code = CMD_RIGHT;
      ASCII_S: r.code = CMD_STOP;
      default: r.ok   = 1'b0;
    endcase
    return r;
  endfunction

  function automatic logic is_digit(input logic [7:0] b);
    return (b >= ASCII_ZERO) && (b <= ASCII_NINE);
  endfunction

endpackage

// File: rtl/uart_command_receiver_if.sv
// Bundles the receiver's three streams (UART rx bytes in, decoded command out,
// acknowledge byte out) plus the error counter.
//   slave  : the receiver itself
//   master : the surrounding UART / controller environment
interface uart_command_receiver_if;
  import robot_cmd_pkg::*;

  logic [7:0] rx_data;
  logic       rx_valid;
  logic       rx_ready;

  cmd_t       cmd_code;
  logic [3:0] cmd_arg;
  logic       cmd_valid;
  logic       cmd_ready;

  logic [7:0] err_count;

  logic [7:0] tx_data;
  logic       tx_valid;
  logic       tx_ready;

  modport master (
    output rx_data, rx_valid, cmd_ready, tx_ready,
    input  rx_ready, cmd_code, cmd_arg, cmd_valid, err_count, tx_data, tx_valid
  );

  modport slave (
    input  rx_data, rx_valid, cmd_ready, tx_ready,
    output rx_ready, cmd_code, cmd_arg, cmd_valid, err_count, tx_data, tx_valid
  );
endinterface

// File: rtl/uart_command_receiver_timebase.sv
// timebase: free-running up-counter with terminal-count flag, used as the
// inter-byte gap timer. Holds at TERMINAL until cleared.
//   clk    : clock
//   rst_n  : asynchronous active-low reset
//   clr_i  : synchronous clear to zero
//   tc_o   : count equals TERMINAL
module timebase #(
  parameter int unsigned          WIDTH    = 30,
  parameter logic [WIDTH-1:0]     TERMINAL = '1
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr_i,
  output logic tc_o
);

  logic [WIDTH-1:0] cnt_q;

  assign tc_o = (cnt_q == TERMINAL);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else if (clr_i) begin
      cnt_q <= '0;
    end else if (!tc_o) begin
      cnt_q <= cnt_q + WIDTH'(1);
    end
  end

endmodule

// File: rtl/uart_command_receiver.sv
// uart_command_receiver: parses "<letter><digit>\n" frames from a UART byte
// stream into a command code and argument, counts rejected frames and
// optionally answers each frame with 'A' / 'N' on the tx stream.
//   clk    : system clock
//   reset  : asynchronous active-low reset
//   bus    : slave side of uart_command_receiver_if (rx in, cmd out, tx out,
//            err_count out)
// Build option: define CMD_ACK_EN to emit the acknowledge byte; otherwise the
// ACK state lasts one cycle and tx_valid/tx_data stay 0.
//
// state    | meaning
// IDLE     | wait for a command letter, other bytes dropped
// GET_ARG  | wait for digit, gap timer armed
// GET_TERM | wait for LF, gap timer armed
// PRESENT  | cmd_valid high until cmd_ready
// ACK      | report ACK/NAK result, then back to IDLE
module uart_command_receiver
  import robot_cmd_pkg::*;
#(
  parameter logic [29:0] TIMEOUT_CYCLES = 30'd50_000_000
) (
  input  logic                    clk,
  input  logic                    reset,
  uart_command_receiver_if.slave  bus
);

`ifdef CMD_ACK_EN
  localparam bit AckEn = 1'b1;
`else
  localparam bit AckEn = 1'b0;
`endif

  state_t     state_q, state_d;
  cmd_t       cmd_code_q, cmd_code_d;
  logic [3:0] cmd_arg_q, cmd_arg_d;
  logic [7:0] err_q, err_d;
  logic       nak_q, nak_d;
  logic       rx_ready_q, cmd_valid_q, tx_valid_q;
  logic [7:0] tx_data_q;

  logic       rx_fire;
  logic       gap_tc;
  logic       gap_clr;
  logic       reject;
  letter_t    letter;

  assign rx_fire = bus.rx_valid && rx_ready_q;
  assign letter  = decode_letter(bus.rx_data);
  // Timer only runs while a frame is partially received.
  assign gap_clr = rx_fire || !(state_q inside {GET_ARG, GET_TERM});

  timebase #(
    .WIDTH    (30),
    .TERMINAL (TIMEOUT_CYCLES - 30'd1)
  ) u_gap (
    .clk   (clk),
    .rst_n (reset),
    .clr_i (gap_clr),
    .tc_o  (gap_tc)
  );

  always_comb begin
    state_d    = state_q;
    cmd_code_d = cmd_code_q;
    cmd_arg_d  = cmd_arg_q;
    err_d      = err_q;
    nak_d      = nak_q;
    reject     = 1'b0;

    case (state_q)
      IDLE: begin
        if (rx_fire && letter.ok) begin
          state_d    = GET_ARG;
          cmd_code_d = letter.code;
        end
      end
      GET_ARG: begin
        // An accepted byte wins over a timeout in the same cycle.
        if (rx_fire) begin
          if (is_digit(bus.rx_data)) begin
            state_d   = GET_TERM;
            // Low nibble of an ASCII digit is its value.
            cmd_arg_d = bus.rx_data[3:0];
          end else begin
            reject = 1'b1;
          end
        end else if (gap_tc) begin
          reject = 1'b1;
        end
      end
      GET_TERM: begin
        if (rx_fire) begin
          if (bus.rx_data == ASCII_LF) state_d = PRESENT;
          else                         reject  = 1'b1;
        end else if (gap_tc) begin
          reject = 1'b1;
        end
      end
      PRESENT: begin
        if (bus.cmd_ready) begin
          state_d = ACK;
          nak_d   = 1'b0;
        end
      end
      ACK: begin
        if (!AckEn || bus.tx_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase

    if (reject) begin
      state_d = ACK;
      nak_d   = 1'b1;
      if (err_q != 8'hFF) err_d = err_q + 8'd1;
    end
  end

  // Outputs are registered from the next state so they read 0 during reset.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= IDLE;
      cmd_code_q  <= CMD_STOP;
      cmd_arg_q   <= '0;
      err_q       <= '0;
      nak_q       <= 1'b0;
      rx_ready_q  <= 1'b0;
      cmd_valid_q <= 1'b0;
      tx_valid_q  <= 1'b0;
      tx_data_q   <= '0;
    end else begin
      state_q     <= state_d;
      cmd_code_q  <= cmd_code_d;
      cmd_arg_q   <= cmd_arg_d;
      err_q       <= err_d;
      nak_q       <= nak_d;
      rx_ready_q  <= (state_d inside {IDLE, GET_ARG, GET_TERM});
      cmd_valid_q <= (state_d == PRESENT);
      tx_valid_q  <= AckEn && (state_d == ACK);
      tx_data_q   <= (AckEn && (state_d == ACK)) ? (nak_d ? NAK_BYTE : ACK_BYTE) : 8'h00;
    end
  end

  assign bus.rx_ready  = rx_ready_q;
  assign bus.cmd_code  = cmd_code_q;
  assign bus.cmd_arg   = cmd_arg_q;
  assign bus.cmd_valid = cmd_valid_q;
  assign bus.err_count = err_q;
  assign bus.tx_valid  = tx_valid_q;
  assign bus.tx_data   = tx_data_q;

endmodule

// File: tb/tb_uart_command_receiver.sv
module tb_uart_command_receiver;
  import robot_cmd_pkg::*;

`ifdef CMD_ACK_EN
  localparam int TX_PER_FRAME = 1;
`else
  localparam int TX_PER_FRAME = 0;
`endif

  logic clk   = 1'b0;
  logic reset = 1'b1;

  int n_assert = 0;
  int n_fail   = 0;

  int cmd_hs       = 0;
  int valid_cycles = 0;
  int tx_hs        = 0;
  int tx_cycles    = 0;
  logic [2:0] last_code = 3'd0;
  logic [3:0] last_arg  = 4'd0;
`ifdef CMD_ACK_EN
  logic [7:0] last_tx   = 8'd0;
`endif

  uart_command_receiver_if bus();

  uart_command_receiver #(.TIMEOUT_CYCLES(30'd100)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (bus.cmd_valid) valid_cycles++;
    if (bus.cmd_valid && bus.cmd_ready) begin
      cmd_hs++;
      last_code = bus.cmd_code;
      last_arg  = bus.cmd_arg;
    end
    if (bus.tx_valid) tx_cycles++;
    if (bus.tx_valid && bus.tx_ready) begin
      tx_hs++;
`ifdef CMD_ACK_EN
      last_tx = bus.tx_data;
`endif
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog observed=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic send_byte(input logic [7:0] b);
    int n;
    n = 0;
    @(negedge clk);
    bus.rx_data  = b;
    bus.rx_valid = 1'b1;
    while (bus.rx_ready !== 1'b1 && n < 50) begin
      @(negedge clk);
      n++;
    end
    check("rx_ready_wait", bus.rx_ready, 1'b1);
    @(posedge clk);
    #1;
    bus.rx_valid = 1'b0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    @(negedge clk);
    reset = 1'b1;
    @(posedge clk);
    #1;
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_rx_ready"},  bus.rx_ready,  1'b0);
    check({tag, "_cmd_valid"}, bus.cmd_valid, 1'b0);
    check({tag, "_cmd_code"},  bus.cmd_code,  3'd0);
    check({tag, "_cmd_arg"},   bus.cmd_arg,   4'd0);
    check({tag, "_err"},       bus.err_count, 8'd0);
    check({tag, "_tx_valid"},  bus.tx_valid,  1'b0);
    check({tag, "_tx_data"},   bus.tx_data,   8'h00);
  endtask

  initial begin
    int b_hs, b_v, b_tx, b_txc, bad;
    bus.rx_data   = 8'h00;
    bus.rx_valid  = 1'b0;
    bus.cmd_ready = 1'b1;
    bus.tx_ready  = 1'b1;

    // Asynchronous reset, checked before any clock edge.
    #2 reset = 1'b0;
    #1 check_reset_outputs("rst_async");
    @(negedge clk);
    @(negedge clk);
    reset = 1'b1;
    @(posedge clk);
    #1 check("rst_release_rx_ready", bus.rx_ready, 1'b1);

    // F3\n with cmd_ready high: one-cycle command, 'A' when acks enabled.
    b_hs = cmd_hs; b_v = valid_cycles; b_tx = tx_hs; b_txc = tx_cycles;
    send_byte(8'h46); send_byte(8'h33); send_byte(8'h0A);
    check("t1_valid_next_cycle", bus.cmd_valid, 1'b1);
    repeat (4) @(posedge clk);
    #1;
    check("t1_handshakes",   cmd_hs - b_hs,       1);
    check("t1_valid_cycles", valid_cycles - b_v,  1);
    check("t1_code",         last_code,           3'd1);
    check("t1_arg",          last_arg,            4'd3);
    check("t1_err",          bus.err_count,       8'd0);
    check("t1_tx_count",     tx_hs - b_tx,        TX_PER_FRAME);
    check("t1_tx_cycles",    tx_cycles - b_txc,   TX_PER_FRAME);
`ifdef CMD_ACK_EN
    check("t1_tx_byte",      last_tx,             8'h41);
`endif

    // SA rejected, then L9\n accepted.
    b_hs = cmd_hs; b_tx = tx_hs;
    send_byte(8'h53); send_byte(8'h41);
    repeat (4) @(posedge clk);
    #1;
    check("t2_no_cmd",   cmd_hs - b_hs,  0);
    check("t2_err",      bus.err_count,  8'd1);
    check("t2_tx_count", tx_hs - b_tx,   TX_PER_FRAME);
`ifdef CMD_ACK_EN
    check("t2_tx_byte",  last_tx,        8'h4E);
`endif
    b_hs = cmd_hs;
    send_byte(8'h4C); send_byte(8'h39); send_byte(8'h0A);
    repeat (4) @(posedge clk);
    #1;
    check("t2_left_hs",   cmd_hs - b_hs, 1);
    check("t2_left_code", last_code,     3'd3);
    check("t2_left_arg",  last_arg,      4'd9);
    check("t2_left_err",  bus.err_count, 8'd1);

    // Timeout: R then silence; reject lands on the 100th edge.
    do_reset();
    send_byte(8'h52);
    repeat (99) @(posedge clk);
    #1;
    check("t3_err_before_tmo",   bus.err_count, 8'd0);
    check("t3_state_before_tmo", dut.state_q,   GET_ARG);
    @(posedge clk);
    #1;
    check("t3_err_at_tmo", bus.err_count, 8'd1);
    repeat (2) @(posedge clk);
    #1;
    check("t3_state_idle", dut.state_q,  IDLE);
    check("t3_rx_ready",   bus.rx_ready, 1'b1);

    // Digit transferred in the very cycle the gap timer expires: byte wins.
    do_reset();
    b_hs = cmd_hs;
    send_byte(8'h52);
    repeat (99) @(posedge clk);
    send_byte(8'h35);
    send_byte(8'h0A);
    repeat (4) @(posedge clk);
    #1;
    check("t3b_err",  bus.err_count, 8'd0);
    check("t3b_hs",   cmd_hs - b_hs, 1);
    check("t3b_code", last_code,     3'd4);
    check("t3b_arg",  last_arg,      4'd5);

    // B7\n with cmd_ready low for 20 cycles.
    do_reset();
    bus.cmd_ready = 1'b0;
    b_hs = cmd_hs; b_v = valid_cycles;
    send_byte(8'h42); send_byte(8'h37); send_byte(8'h0A);
    bad = 0;
    for (int i = 0; i < 20; i++) begin
      @(posedge clk);
      #1;
      if (bus.cmd_valid !== 1'b1 || bus.cmd_code !== CMD_BACK ||
          bus.cmd_arg !== 4'd7 || bus.rx_ready !== 1'b0) bad++;
    end
    check("t4_hold_violations", bad, 0);
    @(negedge clk);
    bus.cmd_ready = 1'b1;
    repeat (4) @(posedge clk);
    #1;
    check("t4_single_hs",    cmd_hs - b_hs,      1);
    check("t4_valid_cycles", valid_cycles - b_v, 21);
    check("t4_valid_low",    bus.cmd_valid,      1'b0);

    // Error counter saturation.
    do_reset();
    for (int i = 0; i < 255; i++) begin
      send_byte(8'h46);
      send_byte(8'h58);
    end
    check("t5_err_255", bus.err_count, 8'd255);
    send_byte(8'h46);
    send_byte(8'h58);
    check("t5_err_sat", bus.err_count, 8'd255);

    // Reset mid-frame after B: everything cleared, stray bytes emit nothing.
    repeat (3) @(posedge clk);
    b_hs = cmd_hs;
    send_byte(8'h42);
    @(negedge clk);
    reset = 1'b0;
    #1 check_reset_outputs("t5_midreset");
    @(negedge clk);
    @(negedge clk);
    reset = 1'b1;
    send_byte(8'h33);
    send_byte(8'h0A);
    repeat (4) @(posedge clk);
    #1;
    check("t5_no_cmd",    cmd_hs - b_hs, 0);
    check("t5_err_clear", bus.err_count, 8'd0);
    check("t5_state",     dut.state_q,   IDLE);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
